// File: rtl/button_conditioner.sv
// button_conditioner: N-channel push-button front end.
// Each channel is synchronized, polarity-normalized and debounced, then
// produces a clean level, one-cycle press/release pulses and optional
// auto-repeat pulses. A chord output reports all channels held at once.
//
// Ports:
//   Clk           in   1  system clock, rising edge
//   Reset         in   1  synchronous active-high reset
//   btn_raw       in   N  asynchronous raw button inputs
//   level         out  N  debounced state, 1 = pressed
//   press         out  N  one-cycle pulse on debounced 0->1
//   release_pulse out  N  one-cycle pulse on debounced 1->0
//   repeat_pulse  out  N  one-cycle auto-repeat pulse (0 when REPEAT_EN=0)
//   chord         out  1  1 while every level bit is 1
//   chord_press   out  1  one-cycle pulse when chord rises
module button_conditioner #(
    parameter int unsigned N               = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] repeat_pulse,
    output logic         chord,
    output logic         chord_press
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

    localparam logic [N-1:0]     IDLE_RAW    = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     s;
    logic [N-1:0]     level_d;
    logic [N-1:0]     press_d;
    logic [N-1:0]     release_d;
    logic [N-1:0]     repeat_d;
    logic             chord_press_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    rpt_state_t       rpt_q [N];
    rpt_state_t       rpt_d [N];
    logic [RC_W-1:0]  rc_q  [N];
    logic [RC_W-1:0]  rc_d  [N];

    // Active-high view of the synchronized buttons.
    assign s     = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;
    assign chord = &level;

    // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing cycles; any agreeing cycle restarts the count.
    always_comb begin
        level_d = level;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // Edge pulses are taken from the next level so they register
        // in the same cycle the new level becomes visible.
        press_d       = level_d & ~level;
        release_d     = ~level_d & level;
        chord_press_d = (&level_d) & ~(&level);
    end

    // Auto-repeat FSM next-state. It also works from the next level, so a
    // pulse scheduled for the release cycle is suppressed.
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N; i++) begin
            rpt_d[i] = rpt_q[i];
            rc_d[i]  = rc_q[i];
            if (REPEAT_EN == 0 || !level_d[i]) begin
                rpt_d[i] = RPT_IDLE;
                rc_d[i]  = '0;
            end else if (press_d[i]) begin
                rpt_d[i] = RPT_DELAY;
                rc_d[i]  = '0;
            end else begin
                case (rpt_q[i])
                    RPT_DELAY: begin
                        if (rc_q[i] == DELAY_LAST) begin
                            repeat_d[i] = 1'b1;
                            rc_d[i]     = '0;
                            rpt_d[i]    = RPT_REPEAT;
                        end else begin
                            rc_d[i] = rc_q[i] + RC_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rc_q[i] == PERIOD_LAST) begin
                            repeat_d[i] = 1'b1;
                            rc_d[i]     = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + RC_W'(1);
                        end
                    end
                    default: begin
                        rpt_d[i] = RPT_IDLE;
                        rc_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    // State registers; sync flops reset to the idle raw value so no
    // spurious edge is seen when Reset deasserts.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= IDLE_RAW;
            end
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            chord_press   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
                rpt_q[i] <= RPT_IDLE;
                rc_q[i]  <= '0;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            level         <= level_d;
            press         <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
            chord_press   <= chord_press_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
                rpt_q[i] <= rpt_d[i];
                rc_q[i]  <= rc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner.
// Scenario tasks drive raw buttons and queue the pulse events the design
// must produce; a negedge monitor pops and compares every cycle, and the
// tasks check level/chord inline at the interesting cycles.
module tb_button_conditioner;

    logic       Clk;
    logic       Reset;
    logic [1:0] btn_raw;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] release_pulse;
    logic [1:0] repeat_pulse;
    logic       chord;
    logic       chord_press;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] rpt;
        logic       cp;
    } ev_t;

    ev_t sb[$];
    ev_t mon_exp;
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 0;
    bit  done     = 0;

    button_conditioner #(
        .N              (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .btn_raw      (btn_raw),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .chord        (chord),
        .chord_press  (chord_press)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // cyc = number of rising edges seen so far.
    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard monitor: every cycle the pulse outputs must equal the queued
    // event for that cycle, or all zero if none is queued.
    always @(negedge Clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event now=%0d expected_at=%0d", cyc, sb[0].cyc);
                sb.delete(0);
            end
            mon_exp.cyc   = cyc;
            mon_exp.press = 2'b00;
            mon_exp.rel   = 2'b00;
            mon_exp.rpt   = 2'b00;
            mon_exp.cp    = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_exp = sb.pop_front();
            end
            checks++;
            if (press !== mon_exp.press || release_pulse !== mon_exp.rel ||
                repeat_pulse !== mon_exp.rpt || chord_press !== mon_exp.cp) begin
                failures++;
                $display("FAIL pulses cyc=%0d press=%b/%b release=%b/%b repeat=%b/%b chord_press=%b/%b (got/exp)",
                         cyc, press, mon_exp.press, release_pulse, mon_exp.rel,
                         repeat_pulse, mon_exp.rpt, chord_press, mon_exp.cp);
            end
        end
    end

    task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] rp, input logic cp);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.rpt   = rp;
        e.cp    = cp;
        sb.push_back(e);
    endtask

    // Advance to just after rising edge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        btn_raw = 2'b11;
        @(posedge Clk);
        #1;
        mon_en = 1'b1;
        goto(3);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (level !== 2'b00 || chord !== 1'b0) begin
            failures++;
            $display("FAIL reset_state level=%b chord=%b exp level=00 chord=0", level, chord);
        end
        goto(cyc + 20);
        @(negedge Clk);
        checks++;
        if (level !== 2'b00 || chord !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle level=%b chord=%b exp level=00 chord=0", level, chord);
        end
    endtask

    task automatic test_clean_press();
        int t0;
        goto(cyc + 1);
        btn_raw[0] = 1'b0;
        t0 = cyc;
        push_ev(t0 + 6,  2'b01, 2'b00, 2'b00, 1'b0);
        push_ev(t0 + 13, 2'b00, 2'b01, 2'b00, 1'b0);
        goto(t0 + 5);
        @(negedge Clk);
        checks++;
        if (level !== 2'b00) begin
            failures++;
            $display("FAIL press_early level=%b exp=00", level);
        end
        goto(t0 + 6);
        @(negedge Clk);
        checks++;
        if (level !== 2'b01) begin
            failures++;
            $display("FAIL press_level level=%b exp=01", level);
        end
        goto(t0 + 7);
        btn_raw[0] = 1'b1;
        goto(t0 + 12);
        @(negedge Clk);
        checks++;
        if (level !== 2'b01) begin
            failures++;
            $display("FAIL release_early level=%b exp=01", level);
        end
        goto(t0 + 13);
        @(negedge Clk);
        checks++;
        if (level !== 2'b00) begin
            failures++;
            $display("FAIL release_level level=%b exp=00", level);
        end
        goto(t0 + 25);
    endtask

    task automatic test_bounce();
        int t0;
        for (int r = 0; r < 5; r++) begin
            btn_raw[0] = 1'b0;
            goto(cyc + 3);
            btn_raw[0] = 1'b1;
            goto(cyc + 1);
        end
        goto(cyc + 6);
        @(negedge Clk);
        checks++;
        if (level !== 2'b00) begin
            failures++;
            $display("FAIL bounce_reject level=%b exp=00", level);
        end
        goto(cyc + 1);
        btn_raw[0] = 1'b0;
        t0 = cyc;
        push_ev(t0 + 6,  2'b01, 2'b00, 2'b00, 1'b0);
        push_ev(t0 + 14, 2'b00, 2'b00, 2'b01, 1'b0);
        push_ev(t0 + 16, 2'b00, 2'b01, 2'b00, 1'b0);
        goto(t0 + 6);
        @(negedge Clk);
        checks++;
        if (level !== 2'b01) begin
            failures++;
            $display("FAIL bounce_accept level=%b exp=01", level);
        end
        goto(t0 + 10);
        btn_raw[0] = 1'b1;
        goto(t0 + 30);
    endtask

    task automatic test_auto_repeat();
        int p;
        goto(cyc + 1);
        btn_raw[0] = 1'b0;
        p = cyc + 6;
        push_ev(p, 2'b01, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            push_ev(p + 8 + 3 * k, 2'b00, 2'b00, 2'b01, 1'b0);
        end
        push_ev(p + 21, 2'b00, 2'b01, 2'b00, 1'b0);
        goto(p + 15);
        btn_raw[0] = 1'b1;
        goto(p + 20);
        @(negedge Clk);
        checks++;
        if (level !== 2'b01) begin
            failures++;
            $display("FAIL repeat_held level=%b exp=01", level);
        end
        goto(p + 21);
        @(negedge Clk);
        checks++;
        if (level !== 2'b00) begin
            failures++;
            $display("FAIL repeat_release level=%b exp=00", level);
        end
        goto(p + 40);
    endtask

    task automatic test_chord();
        int t0;
        goto(cyc + 1);
        btn_raw = 2'b00;
        t0 = cyc;
        push_ev(t0 + 6,  2'b11, 2'b00, 2'b00, 1'b1);
        push_ev(t0 + 13, 2'b00, 2'b10, 2'b00, 1'b0);
        push_ev(t0 + 14, 2'b00, 2'b00, 2'b01, 1'b0);
        push_ev(t0 + 17, 2'b00, 2'b00, 2'b01, 1'b0);
        push_ev(t0 + 20, 2'b10, 2'b00, 2'b01, 1'b1);
        push_ev(t0 + 23, 2'b00, 2'b00, 2'b01, 1'b0);
        push_ev(t0 + 26, 2'b00, 2'b00, 2'b01, 1'b0);
        push_ev(t0 + 27, 2'b00, 2'b11, 2'b00, 1'b0);
        goto(t0 + 6);
        @(negedge Clk);
        checks++;
        if (chord !== 1'b1 || level !== 2'b11) begin
            failures++;
            $display("FAIL chord_on chord=%b level=%b exp chord=1 level=11", chord, level);
        end
        goto(t0 + 7);
        btn_raw[1] = 1'b1;
        goto(t0 + 13);
        @(negedge Clk);
        checks++;
        if (chord !== 1'b0 || level !== 2'b01) begin
            failures++;
            $display("FAIL chord_drop chord=%b level=%b exp chord=0 level=01", chord, level);
        end
        goto(t0 + 14);
        btn_raw[1] = 1'b0;
        goto(t0 + 20);
        @(negedge Clk);
        checks++;
        if (chord !== 1'b1) begin
            failures++;
            $display("FAIL chord_again chord=%b exp=1", chord);
        end
        goto(t0 + 21);
        btn_raw = 2'b11;
        goto(t0 + 27);
        @(negedge Clk);
        checks++;
        if (chord !== 1'b0 || level !== 2'b00) begin
            failures++;
            $display("FAIL chord_off chord=%b level=%b exp chord=0 level=00", chord, level);
        end
        goto(t0 + 40);
    endtask

    task automatic test_reset_mid();
        int t0;
        goto(cyc + 1);
        btn_raw[0] = 1'b0;
        t0 = cyc;
        push_ev(t0 + 11, 2'b01, 2'b00, 2'b00, 1'b0);
        push_ev(t0 + 18, 2'b00, 2'b01, 2'b00, 1'b0);
        goto(t0 + 4);
        Reset = 1'b1;
        goto(t0 + 5);
        Reset = 1'b0;
        goto(t0 + 10);
        @(negedge Clk);
        checks++;
        if (level !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_early level=%b exp=00", level);
        end
        goto(t0 + 11);
        @(negedge Clk);
        checks++;
        if (level !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_press level=%b exp=01", level);
        end
        goto(t0 + 12);
        btn_raw[0] = 1'b1;
        goto(t0 + 30);
    endtask

    initial begin
        Reset   = 1'b1;
        btn_raw = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_chord();
        test_reset_mid();
        goto(cyc + 10);
        @(negedge Clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
        end
        mon_en = 1'b0;
        done   = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            failures++;
            $display("FAIL watchdog cyc=%0d exp=finished", cyc);
            $fatal(1, "bench timeout");
        end
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised N-channel push-button front end: replaces the bare per-button two-flop synchronizer array in the SLC-3 top levels.
- Per channel: synchronize, normalize polarity, debounce, then emit a clean level, one-cycle press/release pulses and optional auto-repeat pulses.
- Also provides an "all channels held" chord output, as used for the Run+Continue reset combination.
- Sits directly behind the board push buttons and feeds the slc3 core's Run, Continue and Reset.

Parameters:
- N, 2: number of button channels, legal 1..16.
- SYNC_STAGES, 2: synchronizer flops per channel, legal 2..4.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a change, legal 1..2^20.
- ACTIVE_LOW, 1: 1 means raw input 0 is pressed; 0 means raw input 1 is pressed.
- REPEAT_EN, 0: 1 enables auto-repeat pulses.
- REPEAT_DELAY, 25000000: cycles from the press pulse to the first repeat pulse, legal ≥2.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses, legal ≥1.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- btn_raw  in  N  asynchronous raw button inputs.
- level  out  N  debounced state; 1 = pressed.
- press  out  N  one-cycle pulse on a debounced 0->1 transition.
- release  out  N  one-cycle pulse on a debounced 1->0 transition.
- repeat_pulse  out  N  one-cycle auto-repeat pulse; tied to 0 when REPEAT_EN=0.
- chord  out  1  1 while all N level bits are 1.
- chord_press  out  1  one-cycle pulse when chord rises.

Behaviour:
- Reset:
  - Sync flops load the idle raw value (1 if ACTIVE_LOW, else 0).
  - level, press, release, repeat_pulse, chord, chord_press and all counters go to 0.
  - No pulse may be generated on the cycles after Reset deasserts unless a real press follows.
- Sync: btn_raw passes through SYNC_STAGES flops. The last stage, XORed with ACTIVE_LOW, gives s[i] (active-high).
- Debounce, per channel, with counter cnt sized to hold DEBOUNCE_CYCLES-1:
  - s == level: cnt <= 0.
  - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any single cycle of agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: after a clean raw change, level updates on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge.
  - DEBOUNCE_CYCLES=1 reduces to the synchronizer plus one flop.
- Pulses are registered and coincident with level:
  - press=1 in exactly the first cycle level reads 1.
  - release=1 in exactly the first cycle level reads 0.
  - press and release are never high together on a channel.
- Auto-repeat (REPEAT_EN=1), per-channel counter rc with states IDLE, DELAY, REPEAT:
  - On press: rc <= 0, enter DELAY.
  - DELAY: when rc == REPEAT_DELAY-1, pulse repeat_pulse, rc <= 0, enter REPEAT.
  - REPEAT: when rc == REPEAT_PERIOD-1, pulse and rc <= 0.
  - level=0 (including the release cycle) forces IDLE, rc <= 0, and no pulse.
  - repeat_pulse never coincides with press.
  - The first repeat pulse occurs REPEAT_DELAY cycles after the press cycle; later pulses are every REPEAT_PERIOD cycles.
  - Counters saturate-free: they wrap only via the compares above.
- Chord:
  - chord is combinational AND of level.
  - chord_press is registered: 1 in the first cycle chord reads 1 after reading 0.
  - Dropping any channel clears chord; re-completing the chord fires chord_press again.
- Reset mid-operation: all debounce and repeat counts are lost.
  - If a button is still held when Reset deasserts, it must re-qualify: a full SYNC_STAGES+DEBOUNCE_CYCLES edges after Reset deasserts before press.
- Channels are fully independent. Simultaneous changes on several channels produce same-cycle pulses on each.

Test Plan:
Bench configuration for all scenarios: N=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Reset idle: Reset=1 for 3 cycles, btn_raw=2'b11, then Reset=0 for 20 cycles -> every output 0 throughout; no pulse.
- Clean press: btn_raw[0] 1->0 just before edge 1 and held -> level[0]=1 after edge 6; press[0]=1 for exactly that one cycle. Raw back to 1 -> release[0] one cycle 6 edges later.
- Bounce reject: btn_raw[0] low 3 cycles, high 1, low 3, high 1, repeated 5 times -> level[0] stays 0, no press. Then low 10 cycles -> press.
- Auto-repeat: hold btn_raw[0] low for 20 cycles after level rises -> repeat_pulse[0] at cycles 8, 11, 14, 17, 20 after the press cycle. Release -> release[0] and no further repeat_pulse.
- Chord: both raw go 0 together -> press[1:0]=2'b11, chord=1 and chord_press=1 in the same cycle, one cycle only. Release ch1 -> chord=0. Re-press ch1 -> chord_press again.
- Reset mid-count: ch0 low, assert Reset when cnt=2, deassert next cycle with ch0 still low -> no press until 6 edges after Reset deasserts, then a single press[0].
